// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive/transmit link.
//   - uart_state_e : receiver FSM state encoding
//   - OVERSAMPLE   : ticks per bit period
//   - EVEN / ODD   : parity-type constants
//   - parity_mismatch, majority3 : small bit-decision helpers
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4,
    BREAK  = 3'd5
  } uart_state_e;

  localparam int   OVERSAMPLE     = 16;
  localparam logic EVEN           = 1'b0;
  localparam logic ODD            = 1'b1;
  localparam int   MAX_DATA_WIDTH = 9;

  // Data is zero-extended by the caller; the extra zeros do not change the XOR.
  function automatic logic parity_mismatch(input logic [MAX_DATA_WIDTH-1:0] data,
                                           input logic pbit,
                                           input logic ptype);
    return (((^data) ^ pbit) != ptype);
  endfunction

  function automatic logic majority3(input logic a, input logic b, input logic c);
    return ((a & b) | (a & c) | (b & c));
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// uart_baud_tick: 16x oversampling tick divider, shared by UART RX and TX.
//   clk  : system clock
//   rst  : synchronous active-high reset
//   clr  : synchronous clear; restarts the divide so ticks phase-align to an event
//   tick : one-clock pulse while the count sits at DIV-1
module uart_baud_tick #(
  parameter int DIV = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int            CW   = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt_r;
  logic [CW-1:0] cnt_nx;

  // Next divider count: clear wins, otherwise count and wrap at DIV-1.
  always_comb begin
    cnt_nx = cnt_r;
    if (clr || (cnt_r == LAST)) begin
      cnt_nx = {CW{1'b0}};
    end else begin
      cnt_nx = cnt_r + CW'(1);
    end
  end

  // Count register plus a registered tick that is high exactly while the count is DIV-1.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_r <= {CW{1'b0}};
      tick  <= 1'b0;
    end else begin
      cnt_r <= cnt_nx;
      tick  <= (cnt_nx == LAST);
    end
  end

endmodule

// File: rtl/uart_rx_os.sv
// uart_rx_os: 16x oversampling UART receiver.
//   clk        : system clock
//   rst        : synchronous active-high reset
//   rx         : asynchronous serial line, idles high
//   rx_data    : received word (LSB first on the line), held until the next rx_valid
//   rx_valid   : one-clock strobe qualifying rx_data and the error flags
//   parity_err : parity mismatch on this frame (0 when parity is disabled)
//   frame_err  : stop bit sampled low
//   busy       : high from start-bit detection until the FSM returns to IDLE
// Optional build macro UART_RX_MAJORITY_EN: every bit decision becomes a 2-of-3
// vote over the two preceding ticks and the decision tick.
module uart_rx_os
  import uart_pkg::*;
#(
  parameter int CLK_FREQ      = 50000000,
  parameter int BAUD_RATE     = 9600,
  parameter int DATA_WIDTH    = 8,
  parameter int PARITY_ENABLE = 1,
  parameter int PARITY_TYPE   = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  rx,
  output logic [DATA_WIDTH-1:0] rx_data,
  output logic                  rx_valid,
  output logic                  parity_err,
  output logic                  frame_err,
  output logic                  busy
);

  localparam int         DIV_RAW  = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
  localparam int         DIV      = (DIV_RAW < 1) ? 1 : DIV_RAW;
  localparam logic [3:0] LAST_BIT = 4'(DATA_WIDTH - 1);
  localparam logic       PAR_ON   = (PARITY_ENABLE != 0);
  localparam logic       PAR_TYPE = (PARITY_TYPE != 0) ? ODD : EVEN;

  logic [1:0]            rx_sync_r;
  logic                  rx_s;
  logic                  tick_s;
  logic                  clr_s;
  uart_state_e           state_r, state_nx;
  logic [3:0]            samp_cnt_r, samp_cnt_nx;
  logic [3:0]            bit_cnt_r, bit_cnt_nx;
  logic [DATA_WIDTH-1:0] shift_r, shift_nx;
  logic                  pbit_r, pbit_nx;
  logic [3:0]            mid_cnt_s;
  logic                  dec_s;
  logic                  bit_s;
  logic                  done_s;

  // Two-flop synchroniser; idles high so reset does not look like a start bit.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_sync_r <= 2'b11;
    end else begin
      rx_sync_r <= {rx_sync_r[0], rx};
    end
  end
  assign rx_s = rx_sync_r[1];

  // Restart the divider as the FSM leaves IDLE so ticks line up with the start edge.
  assign clr_s = (state_r == IDLE) && !rx_s;

  uart_baud_tick #(.DIV(DIV)) u_baud_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (clr_s),
    .tick (tick_s)
  );

  // Start bit is judged at mid-bit (count 7); later bits one full bit on (count 15).
  assign mid_cnt_s = (state_r == START) ? 4'd7 : 4'd15;
  assign dec_s     = tick_s && (samp_cnt_r == mid_cnt_s);

`ifdef UART_RX_MAJORITY_EN
  logic samp_a_r;
  logic samp_b_r;

  // Capture the two early votes taken two ticks and one tick before each decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      samp_a_r <= 1'b1;
      samp_b_r <= 1'b1;
    end else if (tick_s && (samp_cnt_r == (mid_cnt_s - 4'd2))) begin
      samp_a_r <= rx_s;
    end else if (tick_s && (samp_cnt_r == (mid_cnt_s - 4'd1))) begin
      samp_b_r <= rx_s;
    end
  end
  assign bit_s = majority3(samp_a_r, samp_b_r, rx_s);
`else
  assign bit_s = rx_s;
`endif

  // Next-state and datapath updates for the receive FSM.
  always_comb begin
    state_nx    = state_r;
    samp_cnt_nx = samp_cnt_r;
    bit_cnt_nx  = bit_cnt_r;
    shift_nx    = shift_r;
    pbit_nx     = pbit_r;
    done_s      = 1'b0;
    if (tick_s) begin
      samp_cnt_nx = samp_cnt_r + 4'd1;
    end else begin
      samp_cnt_nx = samp_cnt_r;
    end
    case (state_r)
      IDLE: begin
        if (!rx_s) begin
          state_nx    = START;
          samp_cnt_nx = 4'd0;
        end else begin
          state_nx = IDLE;
        end
      end
      START: begin
        if (dec_s && bit_s) begin
          state_nx = IDLE;
        end else if (dec_s) begin
          state_nx    = DATA;
          samp_cnt_nx = 4'd0;
          bit_cnt_nx  = 4'd0;
        end else begin
          state_nx = START;
        end
      end
      DATA: begin
        if (dec_s) begin
          shift_nx   = {bit_s, shift_r[DATA_WIDTH-1:1]};
          bit_cnt_nx = bit_cnt_r + 4'd1;
          if (bit_cnt_r == LAST_BIT) begin
            state_nx = PAR_ON ? PARITY : STOP;
          end else begin
            state_nx = DATA;
          end
        end else begin
          state_nx = DATA;
        end
      end
      PARITY: begin
        if (dec_s) begin
          pbit_nx  = bit_s;
          state_nx = STOP;
        end else begin
          state_nx = PARITY;
        end
      end
      STOP: begin
        // Leaving at mid-stop lets a following start edge be caught with zero idle.
        if (dec_s) begin
          done_s   = 1'b1;
          state_nx = bit_s ? IDLE : BREAK;
        end else begin
          state_nx = STOP;
        end
      end
      BREAK: begin
        if (rx_s) begin
          state_nx = IDLE;
        end else begin
          state_nx = BREAK;
        end
      end
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // FSM and datapath registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r    <= IDLE;
      samp_cnt_r <= 4'd0;
      bit_cnt_r  <= 4'd0;
      shift_r    <= {DATA_WIDTH{1'b0}};
      pbit_r     <= 1'b0;
    end else begin
      state_r    <= state_nx;
      samp_cnt_r <= samp_cnt_nx;
      bit_cnt_r  <= bit_cnt_nx;
      shift_r    <= shift_nx;
      pbit_r     <= pbit_nx;
    end
  end

  // Registered outputs: word and flags are presented the clock after the mid-stop decision.
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_data    <= {DATA_WIDTH{1'b0}};
      rx_valid   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      busy       <= 1'b0;
    end else begin
      rx_valid <= done_s;
      busy     <= (state_nx != IDLE);
      if (done_s) begin
        rx_data    <= shift_r;
        parity_err <= PAR_ON ? parity_mismatch(MAX_DATA_WIDTH'(shift_r), pbit_r, PAR_TYPE) : 1'b0;
        frame_err  <= !bit_s;
      end else begin
        parity_err <= 1'b0;
        frame_err  <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os.sv
// tb_uart_rx_os: self-checking bench for uart_rx_os at 32 clocks per bit.
// Two instances share clk/rst/rx: one with even parity, one with odd parity.
module tb_uart_rx_os;

  localparam int BIT_CLKS = 32;
  // Stop decision sits 10 bit-times plus half a bit after the start edge,
  // plus 2 synchroniser clocks and 1 output register clock.
  localparam int FRAME_LAT = BIT_CLKS * 10 + BIT_CLKS / 2 + 2 + 1;

  typedef struct packed {
    logic [7:0]  d;
    logic        pe;
    logic        fe;
    logic [31:0] cyc;
  } rec_t;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx;
  logic [7:0] data_e, data_o;
  logic       valid_e, valid_o, perr_e, perr_o, ferr_e, ferr_o, busy_e, busy_o;
  logic       glitch_en = 1'b0;
  int         cyc = 0;
  int         tests_run = 0;
  int         failed = 0;
  rec_t       q_e[$];
  rec_t       q_o[$];

  uart_rx_os #(.CLK_FREQ(32000000), .BAUD_RATE(1000000), .DATA_WIDTH(8),
               .PARITY_ENABLE(1), .PARITY_TYPE(0)) dut_even (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(data_e), .rx_valid(valid_e),
    .parity_err(perr_e), .frame_err(ferr_e), .busy(busy_e));

  uart_rx_os #(.CLK_FREQ(32000000), .BAUD_RATE(1000000), .DATA_WIDTH(8),
               .PARITY_ENABLE(1), .PARITY_TYPE(1)) dut_odd (
    .clk(clk), .rst(rst), .rx(rx), .rx_data(data_o), .rx_valid(valid_o),
    .parity_err(perr_o), .frame_err(ferr_o), .busy(busy_o));

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Record every valid strobe with the cycle it was seen.
  always @(negedge clk) begin
    if (valid_e) q_e.push_back({data_e, perr_e, ferr_e, 32'(cyc)});
    if (valid_o) q_o.push_back({data_o, perr_o, ferr_o, 32'(cyc)});
  end

  // Reference: what a frame should report, from the line-level frame contents.
  function automatic rec_t model(input logic [7:0] d, input logic pbit, input logic stop,
                                 input logic odd, input int sc);
    rec_t r;
    r.d   = d;
    r.pe  = (((^d) ^ pbit) != odd);
    r.fe  = !stop;
    r.cyc = 32'(sc + FRAME_LAT);
    return r;
  endfunction

  task automatic send_bit(input logic b, input int n);
    for (int c = 0; c < n; c++) begin
      rx = (glitch_en && (c == 14)) ? ~b : b;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] d, input logic pbit, input logic stop,
                            input int stop_len, output int sc);
    sc = cyc;
    send_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 8; i++) send_bit(d[i], BIT_CLKS);
    send_bit(pbit, BIT_CLKS);
    send_bit(stop, stop_len);
  endtask

  task automatic test_reset;
    rst = 1'b1;
    rx  = 1'b1;
    repeat (3) @(negedge clk);
    tests_run++;
    if ({data_e, valid_e, perr_e, ferr_e, busy_e, data_o, valid_o, busy_o} !== 21'd0) begin
      failed++;
      $display("FAIL reset_outputs: got data=%h valid=%b pe=%b fe=%b busy=%b, want all 0",
               data_e, valid_e, perr_e, ferr_e, busy_e);
    end
    rst = 1'b0;
    send_bit(1'b1, 8);
    tests_run++;
    if ({valid_e, busy_e} !== 2'b00) begin
      failed++;
      $display("FAIL idle_after_reset: got valid=%b busy=%b, want 0 0", valid_e, busy_e);
    end
  endtask

  task automatic test_basic;
    int   sc;
    rec_t exp;
    q_e.delete();
    send_frame(8'hA5, 1'b0, 1'b1, BIT_CLKS, sc);
    exp = model(8'hA5, 1'b0, 1'b1, 1'b0, sc);
    tests_run++;
    if (q_e.size() != 1) begin
      failed++;
      $display("FAIL a5_count: got %0d pulses, want 1", q_e.size());
    end else begin
      tests_run++;
      if (q_e[0] !== exp) begin
        failed++;
        $display("FAIL a5_frame: got d=%h pe=%b fe=%b cyc=%0d, want d=%h pe=%b fe=%b cyc=%0d",
                 q_e[0].d, q_e[0].pe, q_e[0].fe, q_e[0].cyc, exp.d, exp.pe, exp.fe, exp.cyc);
      end
    end
    tests_run++;
    if (busy_e !== 1'b0) begin
      failed++;
      $display("FAIL a5_busy_after_stop: got %b, want 0", busy_e);
    end
    send_bit(1'b1, 40);
    tests_run++;
    if ({data_e, perr_e, ferr_e} !== {8'hA5, 2'b00}) begin
      failed++;
      $display("FAIL a5_hold: got data=%h pe=%b fe=%b, want a5 0 0", data_e, perr_e, ferr_e);
    end
  endtask

  task automatic test_parity_err;
    int   sc;
    rec_t exp;
    q_e.delete();
    send_frame(8'h07, 1'b0, 1'b1, BIT_CLKS, sc);
    exp = model(8'h07, 1'b0, 1'b1, 1'b0, sc);
    send_bit(1'b1, 10);
    tests_run++;
    if (q_e.size() != 1) begin
      failed++;
      $display("FAIL parity_count: got %0d pulses, want 1", q_e.size());
    end else begin
      tests_run++;
      if (q_e[0] !== exp) begin
        failed++;
        $display("FAIL parity_frame: got d=%h pe=%b fe=%b, want d=%h pe=%b fe=%b",
                 q_e[0].d, q_e[0].pe, q_e[0].fe, exp.d, exp.pe, exp.fe);
      end
    end
  endtask

  task automatic test_break;
    int   sc, sc2;
    rec_t exp, exp2;
    q_e.delete();
    send_frame(8'h55, 1'b0, 1'b0, 160, sc);
    exp = model(8'h55, 1'b0, 1'b0, 1'b0, sc);
    tests_run++;
    if (q_e.size() != 1) begin
      failed++;
      $display("FAIL break_count: got %0d pulses, want 1", q_e.size());
    end else begin
      tests_run++;
      if (q_e[0] !== exp) begin
        failed++;
        $display("FAIL break_frame: got d=%h pe=%b fe=%b cyc=%0d, want d=%h pe=%b fe=%b cyc=%0d",
                 q_e[0].d, q_e[0].pe, q_e[0].fe, q_e[0].cyc, exp.d, exp.pe, exp.fe, exp.cyc);
      end
    end
    tests_run++;
    if (busy_e !== 1'b1) begin
      failed++;
      $display("FAIL break_busy_low_line: got %b, want 1", busy_e);
    end
    send_bit(1'b1, BIT_CLKS);
    tests_run++;
    if (busy_e !== 1'b0) begin
      failed++;
      $display("FAIL break_busy_released: got %b, want 0", busy_e);
    end
    send_frame(8'h12, 1'b0, 1'b1, BIT_CLKS, sc2);
    exp2 = model(8'h12, 1'b0, 1'b1, 1'b0, sc2);
    tests_run++;
    if (q_e.size() != 2) begin
      failed++;
      $display("FAIL break_recover_count: got %0d pulses, want 2", q_e.size());
    end else begin
      tests_run++;
      if (q_e[1] !== exp2) begin
        failed++;
        $display("FAIL break_recover_frame: got d=%h pe=%b fe=%b, want d=%h pe=%b fe=%b",
                 q_e[1].d, q_e[1].pe, q_e[1].fe, exp2.d, exp2.pe, exp2.fe);
      end
    end
  endtask

  task automatic test_glitch;
    q_e.delete();
    send_bit(1'b0, 5);
    tests_run++;
    if (busy_e !== 1'b1) begin
      failed++;
      $display("FAIL glitch_busy_rise: got %b, want 1", busy_e);
    end
    send_bit(1'b0, 1);
    send_bit(1'b1, 25);
    tests_run++;
    if (busy_e !== 1'b0) begin
      failed++;
      $display("FAIL glitch_busy_fall: got %b, want 0", busy_e);
    end
    send_bit(1'b1, 100);
    tests_run++;
    if (q_e.size() != 0) begin
      failed++;
      $display("FAIL glitch_no_valid: got %0d pulses, want 0", q_e.size());
    end
  endtask

  task automatic test_back_to_back;
    int   sc0, sc1;
    rec_t exp0, exp1;
    q_o.delete();
    send_frame(8'h00, 1'b1, 1'b1, BIT_CLKS, sc0);
    send_frame(8'hFF, 1'b1, 1'b1, BIT_CLKS, sc1);
    exp0 = model(8'h00, 1'b1, 1'b1, 1'b1, sc0);
    exp1 = model(8'hFF, 1'b1, 1'b1, 1'b1, sc1);
    send_bit(1'b1, 20);
    tests_run++;
    if (q_o.size() != 2) begin
      failed++;
      $display("FAIL b2b_count: got %0d pulses, want 2", q_o.size());
    end else begin
      tests_run++;
      if ((q_o[0] !== exp0) || (q_o[1] !== exp1)) begin
        failed++;
        $display("FAIL b2b_frames: got %h/%b%b then %h/%b%b, want %h/%b%b then %h/%b%b",
                 q_o[0].d, q_o[0].pe, q_o[0].fe, q_o[1].d, q_o[1].pe, q_o[1].fe,
                 exp0.d, exp0.pe, exp0.fe, exp1.d, exp1.pe, exp1.fe);
      end
    end
  endtask

  task automatic test_reset_midframe;
    int         sc;
    rec_t       exp;
    logic [7:0] d81;
    d81 = 8'h81;
    q_e.delete();
    q_o.delete();
    send_bit(1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) send_bit(d81[i], BIT_CLKS);
    send_bit(d81[4], 10);
    rst = 1'b1;
    rx  = 1'b1;
    @(negedge clk);
    tests_run++;
    if ({data_e, valid_e, perr_e, ferr_e, busy_e, data_o, busy_o} !== 20'd0) begin
      failed++;
      $display("FAIL midframe_reset_outputs: got data=%h valid=%b pe=%b fe=%b busy=%b, want all 0",
               data_e, valid_e, perr_e, ferr_e, busy_e);
    end
    rst = 1'b0;
    send_bit(1'b1, 64);
    tests_run++;
    if ((q_e.size() != 0) || (q_o.size() != 0)) begin
      failed++;
      $display("FAIL midframe_no_partial: got %0d/%0d pulses, want 0", q_e.size(), q_o.size());
    end
`ifdef UART_RX_MAJORITY_EN
    glitch_en = 1'b1;
`endif
    send_frame(8'h3C, 1'b0, 1'b1, BIT_CLKS, sc);
    glitch_en = 1'b0;
    exp = model(8'h3C, 1'b0, 1'b1, 1'b0, sc);
    send_bit(1'b1, 20);
    tests_run++;
    if (q_e.size() != 1) begin
      failed++;
      $display("FAIL 3c_count: got %0d pulses, want 1", q_e.size());
    end else begin
      tests_run++;
      if (q_e[0] !== exp) begin
        failed++;
        $display("FAIL 3c_frame: got d=%h pe=%b fe=%b cyc=%0d, want d=%h pe=%b fe=%b cyc=%0d",
                 q_e[0].d, q_e[0].pe, q_e[0].fe, q_e[0].cyc, exp.d, exp.pe, exp.fe, exp.cyc);
      end
    end
  endtask

  task automatic test_random;
    int         sc, gap;
    logic [7:0] d;
    logic       pbit;
    rec_t       exp;
    for (int n = 0; n < 8; n++) begin
      q_e.delete();
      d    = 8'($urandom_range(0, 255));
      pbit = 1'($urandom_range(0, 1));
      gap  = $urandom_range(0, 20);
      send_frame(d, pbit, 1'b1, BIT_CLKS, sc);
      exp = model(d, pbit, 1'b1, 1'b0, sc);
      send_bit(1'b1, gap);
      tests_run++;
      if ((q_e.size() != 1) || (q_e[0] !== exp)) begin
        failed++;
        $display("FAIL random_frame_%0d: got %0d pulses first=%h, want 1 pulse d=%h pe=%b fe=%b cyc=%0d",
                 n, q_e.size(), (q_e.size() > 0) ? q_e[0] : '0, exp.d, exp.pe, exp.fe, exp.cyc);
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_parity_err();
    test_break();
    test_glitch();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests_run, failed);
    $finish;
  end

endmodule

// File: doc/uart_rx_os.md
Name: uart_rx_os

Overview:
- Standalone 16x-oversampling UART receiver, the far end of the team's UART transmitter link.
- Synchronises the asynchronous serial line and validates the start bit at mid-bit.
- Samples each data, parity and stop bit at its centre, then presents the word with a one-cycle valid strobe plus parity and framing error flags.
- Sits between the board RX pin and the command or FIFO logic.

Parameters:
- CLK_FREQ, 50000000, system clock frequency in Hz.
- BAUD_RATE, 9600, line baud rate.
- DATA_WIDTH, 8, data bits per frame (5..9).
- PARITY_ENABLE, 1, 1 = frame carries a parity bit after the data; 0 = no parity bit.
- PARITY_TYPE, 0, 0 = even parity, 1 = odd parity (ignored when PARITY_ENABLE=0).

Ports:
- clk  input  1  system clock.
- rst  input  1  reset: synchronous, active-high; one clock for the whole block.
- rx  input  1  asynchronous serial line; idles high.
- rx_data  output  DATA_WIDTH  received word, LSB first on the line; holds its value until the next rx_valid.
- rx_valid  output  1  one-clock pulse; rx_data and the error flags are valid in that cycle.
- parity_err  output  1  parity mismatch on this frame; valid with rx_valid, forced 0 when PARITY_ENABLE=0.
- frame_err  output  1  stop bit sampled low; valid with rx_valid.
- busy  output  1  high from start-bit detection until return to IDLE.

Behaviour:
- Reset: rx_data=0, rx_valid=0, parity_err=0, frame_err=0, busy=0, FSM=IDLE, tick divider=0, synchroniser flops=1.
- Synchroniser: rx passes through 2 flops (rx_s). All logic uses rx_s, giving 2 clocks of input latency.
- Tick generator: DIV = CLK_FREQ/(BAUD_RATE*16), integer floor, DIV >= 1.
  - Counter runs 0..DIV-1; tick pulses when the count is DIV-1.
  - Counter is cleared in the cycle the FSM leaves IDLE, so ticks phase-align to the start edge.
- Sample counter: 4-bit, increments on each tick, wraps 15->0.
- FSM state IDLE:
  - rx_s=0 -> START; sample counter=0; busy=1.
- FSM state START:
  - On the tick where sample count=7 (mid start bit): rx_s=0 -> DATA, sample counter=0, bit counter=0.
  - Same tick with rx_s=1 -> IDLE (glitch rejected; no rx_valid).
- FSM state DATA:
  - On the tick where count=15, shift rx_s into the shift register MSB (LSB-first assembly) and increment the bit counter.
  - After DATA_WIDTH bits -> PARITY if PARITY_ENABLE, else STOP.
- FSM state PARITY:
  - On count=15, capture the parity bit -> STOP.
  - Error when (^data ^ pbit) != PARITY_TYPE.
- FSM state STOP:
  - On count=15, sample the stop bit.
  - Next clock: rx_data <= shift register; rx_valid=1; flags set.
  - Stop bit 1 -> IDLE.
  - Stop bit 0 -> frame_err=1 -> BREAK.
- FSM state BREAK:
  - Wait for rx_s=1, then -> IDLE.
  - Prevents a held-low line (break) from retriggering frames.
- Timing:
  - rx_valid rises 1 clock after the mid-stop tick.
  - The FSM returns to IDLE at mid-stop, so back-to-back frames with zero idle are received.
- Flags:
  - parity_err and frame_err reflect only the current frame.
  - Both are cleared in the cycle after rx_valid.
- rst mid-frame: aborts immediately to the reset values; no partial rx_valid.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: each decision (start validation and every data, parity and stop bit) uses a 2-of-3 majority of rx_s.
  - Start bit: samples at counts 5, 6, 7.
  - All other bits: samples at counts 13, 14, 15.
  - Decision timing is unchanged.
- Undefined: single sample at count 7 (start) or count 15 (other bits); the sample registers are absent.

Decomposition:
- uart_pkg holds:
  - the FSM state encoding (IDLE, START, DATA, PARITY, STOP, BREAK);
  - OVERSAMPLE=16;
  - the parity-type constants EVEN=0 and ODD=1.
- One sub-module, uart_baud_tick: the 16x tick divider with synchronous clear input. The same tick generator is to be reused by the transmitter.

Test Plan:
- Bench parameters: CLK_FREQ=32000000, BAUD_RATE=1000000, giving DIV=2 and 32 clocks per bit. Scenarios 1-4 and 6 use PARITY_TYPE=0 (even); scenario 5 overrides it.
1. Frame 0xA5, parity 0, stop 1 -> rx_data=0xA5, one rx_valid pulse, parity_err=0, frame_err=0, busy low after mid-stop.
2. Frame 0x07, parity bit 0 (wrong) -> rx_data=0x07, rx_valid with parity_err=1, frame_err=0.
3. Frame 0x55 with stop=0, line then held low for 160 clocks -> one rx_valid with frame_err=1; no further rx_valid until the line goes high and a new frame 0x12 arrives, which gives 0x12 with no errors.
4. Low glitch of 6 clocks on an idle line -> no rx_valid; busy pulses, then returns to 0 by mid-start.
5. Back-to-back 0x00 then 0xFF with no idle gap, PARITY_TYPE=1 -> two rx_valid pulses, data 0x00 then 0xFF, no errors.
6. Assert rst for 1 clock midway through the data bits of 0x81, then send 0x3C -> all outputs 0 during reset; 0x81 is never reported; 0x3C received cleanly. With UART_RX_MAJORITY_EN, repeat this frame with 1-clock glitches at count 14 of every bit -> still 0x3C.
